// File: rtl/druaga_ioctl_pkg.sv
// Shared types for the ioctl download dispatcher: sink indices, FSM states,
// the ROM FIFO entry layout and the DIP-switch packing rule.
package druaga_ioctl_pkg;

  localparam int         IOCTL_ADDR_W = 25;
  localparam logic [7:0] IDX_ROM      = 8'd0;
  localparam logic [7:0] IDX_TNO      = 8'd1;
  localparam logic [7:0] IDX_DIP      = 8'd254;

  typedef enum logic [1:0] {
    LOAD,
    DRAIN,
    HOLD,
    RUN
  } state_e;

  typedef struct packed {
    logic [IOCTL_ADDR_W-1:0] addr;
    logic [7:0]              data;
  } fifo_entry_t;

  // Some titles reuse switch bank bits in the top byte; the title number picks the layout.
  function automatic logic [23:0] pack_dsw(input logic [3:0] tno, input logic [7:0] sw0,
                                           input logic [7:0] sw1, input logic [7:0] sw2);
    case (tno)
      4'd1, 4'd3: return {sw1[3:0], sw2[3:0], sw1, sw0};
      4'd2:       return {sw2[3:0], sw2[3:0], sw1, sw0};
      default:    return {sw2, sw1, sw0};
    endcase
  endfunction

endpackage

// File: rtl/ioctl_fifo.sv
// Small synchronous FIFO for ROM bytes. Push at full is ignored unless a pop
// frees the head slot in the same cycle.
module ioctl_fifo
  import druaga_ioctl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  fifo_entry_t       wdata,
  output fifo_entry_t       rdata,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = $clog2(DEPTH);

  fifo_entry_t            mem_q [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage has no reset; entries are only meaningful while count says so.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/ioctl_dispatch.sv
// Routes the HPS ioctl download stream to ROM, title-number and DIP sinks,
// sequences ROM bytes onto a req/ack port and owns the game core reset.
module ioctl_dispatch
  import druaga_ioctl_pkg::*;
#(
  parameter int         ADDR_W     = IOCTL_ADDR_W,
  parameter int         FIFO_DEPTH = 4,
  parameter int         RST_HOLD   = 1024,
  parameter logic [7:0] ROM_IDX    = IDX_ROM,
  parameter logic [7:0] TNO_IDX    = IDX_TNO,
  parameter logic [7:0] DIP_IDX    = IDX_DIP
) (
  input  logic              clk_sys,
  input  logic              RESET,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [7:0]        ioctl_index,
  input  logic [ADDR_W-1:0] ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  input  logic              rst_req,
  output logic              rom_req,
  input  logic              rom_ack,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [7:0]        rom_data,
  output logic [3:0]        tno,
  output logic [23:0]       dsw,
  output logic              core_reset,
  output logic              overflow
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int HOLD_W = $clog2(RST_HOLD + 1);

  state_e            state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              core_reset_q, core_reset_d;
  logic              dl_q;
  logic              ioctl_wait_q, ioctl_wait_d;
  logic              overflow_q, overflow_d;
  logic [3:0]        tno_q, tno_d;
  logic [2:0][7:0]   sw_q, sw_d;
  logic [23:0]       dsw_q, dsw_d;

  fifo_entry_t       fifo_wdata, fifo_head;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic              rom_push, rom_pop, dl_rise, fifo_drains;

  assign rom_push = ioctl_wr && ioctl_download && (ioctl_index == ROM_IDX);
  assign rom_pop  = rom_ack && !fifo_empty;
  assign dl_rise  = ioctl_download && !dl_q;
  // True when the FIFO is empty now or its last entry leaves this cycle.
  assign fifo_drains = fifo_empty ||
                       ((fifo_count == CNT_W'(1)) && rom_pop && !rom_push);

  always_comb begin
    fifo_wdata      = '0;
    fifo_wdata.addr = IOCTL_ADDR_W'(ioctl_addr);
    fifo_wdata.data = ioctl_dout;
  end

  ioctl_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk_sys),
    .rst   (RESET),
    .push  (rom_push),
    .pop   (rom_pop),
    .wdata (fifo_wdata),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign rom_req    = !fifo_empty;
  assign rom_addr   = ADDR_W'(fifo_head.addr);
  assign rom_data   = fifo_head.data;
  assign ioctl_wait = ioctl_wait_q;
  assign overflow   = overflow_q;
  assign tno        = tno_q;
  assign dsw        = dsw_q;
  assign core_reset = core_reset_q;

  // Side-channel sinks: accepted in every state, independent of the FSM.
  always_comb begin
    tno_d = tno_q;
    sw_d  = sw_q;
    if (ioctl_wr && (ioctl_index == TNO_IDX)) tno_d = ioctl_dout[3:0];
    if (ioctl_wr && (ioctl_index == DIP_IDX) && (ioctl_addr[ADDR_W-1:3] == '0)) begin
      case (ioctl_addr[2:0])
        3'd0:    sw_d[0] = ioctl_dout;
        3'd1:    sw_d[1] = ioctl_dout;
        3'd2:    sw_d[2] = ioctl_dout;
        default: sw_d    = sw_q;
      endcase
    end
    dsw_d        = pack_dsw(tno_q, sw_q[0], sw_q[1], sw_q[2]);
    ioctl_wait_d = (fifo_count >= CNT_W'(FIFO_DEPTH - 1));
    overflow_d   = overflow_q;
    if (dl_rise) overflow_d = 1'b0;
    if (rom_push && fifo_full && !rom_pop) overflow_d = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    if (dl_rise) begin
      state_d    = LOAD;
      hold_cnt_d = '0;
    end else begin
      case (state_q)
        LOAD: begin
          if (!ioctl_download) begin
            state_d    = fifo_drains ? HOLD : DRAIN;
            hold_cnt_d = '0;
          end
        end
        DRAIN: begin
          if (fifo_drains) begin
            state_d    = HOLD;
            hold_cnt_d = '0;
          end
        end
        HOLD: begin
          if (rst_req) begin
            hold_cnt_d = '0;
          end else if (hold_cnt_q == HOLD_W'(RST_HOLD - 1)) begin
            state_d = RUN;
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          end
        end
        RUN: begin
          if (rst_req) begin
            state_d    = HOLD;
            hold_cnt_d = '0;
          end
        end
        default: state_d = HOLD;
      endcase
    end
    core_reset_d = (state_d != RUN);
  end

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      state_q      <= HOLD;
      hold_cnt_q   <= '0;
      core_reset_q <= 1'b1;
      dl_q         <= 1'b0;
      ioctl_wait_q <= 1'b0;
      overflow_q   <= 1'b0;
      tno_q        <= '0;
      sw_q         <= '0;
      dsw_q        <= '0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      core_reset_q <= core_reset_d;
      dl_q         <= ioctl_download;
      ioctl_wait_q <= ioctl_wait_d;
      overflow_q   <= overflow_d;
      tno_q        <= tno_d;
      sw_q         <= sw_d;
      dsw_q        <= dsw_d;
    end
  end

endmodule

// File: tb/tb_ioctl_dispatch.sv
// Scoreboard bench for ioctl_dispatch: stimulus pushes expected ROM writes,
// a negedge monitor pops and compares whenever the DUT completes a transfer.
module tb_ioctl_dispatch;

  localparam int ADDR_W = 25;
  localparam int DEPTH  = 4;
  localparam int HOLD   = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } rom_t;

  logic              clk_sys = 1'b0;
  logic              RESET = 1'b1;
  logic              ioctl_download = 1'b0;
  logic              ioctl_wr = 1'b0;
  logic [7:0]        ioctl_index = '0;
  logic [ADDR_W-1:0] ioctl_addr = '0;
  logic [7:0]        ioctl_dout = '0;
  logic              ioctl_wait;
  logic              rst_req = 1'b0;
  logic              rom_req;
  logic              rom_ack = 1'b0;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data;
  logic [3:0]        tno;
  logic [23:0]       dsw;
  logic              core_reset;
  logic              overflow;

  ioctl_dispatch #(
    .ADDR_W     (ADDR_W),
    .FIFO_DEPTH (DEPTH),
    .RST_HOLD   (HOLD)
  ) dut (
    .clk_sys        (clk_sys),
    .RESET          (RESET),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_index    (ioctl_index),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .rst_req        (rst_req),
    .rom_req        (rom_req),
    .rom_ack        (rom_ack),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .tno            (tno),
    .dsw            (dsw),
    .core_reset     (core_reset),
    .overflow       (overflow)
  );

  always #5 clk_sys = ~clk_sys;

  int   checks = 0;
  int   errors = 0;
  rom_t exp_q[$];
  int   n_xfer = 0;
  bit   mon_en = 1'b0;
  int   fill_prev = 0;
  int   mon_fill;
  rom_t mon_e;

  logic [7:0] sw_m [3];
  logic [3:0] tno_m = '0;
  bit         ovf_m = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] exp_dsw();
    if (tno_m == 4'd1 || tno_m == 4'd3) return {sw_m[1][3:0], sw_m[2][3:0], sw_m[1], sw_m[0]};
    if (tno_m == 4'd2)                  return {sw_m[2][3:0], sw_m[2][3:0], sw_m[1], sw_m[0]};
    return {sw_m[2], sw_m[1], sw_m[0]};
  endfunction

  // Monitor: request level, head presentation, wait flag and completed transfers.
  always @(negedge clk_sys) begin
    if (mon_en) begin
      mon_fill = exp_q.size();
      check("rom_req", rom_req, mon_fill != 0);
      check("ioctl_wait", ioctl_wait, fill_prev >= DEPTH - 1);
      fill_prev = mon_fill;
      if (rom_req && mon_fill != 0) begin
        check("rom_addr", rom_addr, exp_q[0].addr);
        check("rom_data", rom_data, exp_q[0].data);
        if (rom_ack) begin
          mon_e = exp_q.pop_front();
          n_xfer++;
        end
      end
    end
  end

  // One clock cycle of stimulus; called at posedge+1, returns at the next posedge+1.
  task automatic drive_cycle(input bit wr, input logic [7:0] idx, input logic [ADDR_W-1:0] addr,
                             input logic [7:0] dout, input bit ack);
    bit   acc, drop;
    rom_t e;
    ioctl_wr = wr; ioctl_index = idx; ioctl_addr = addr; ioctl_dout = dout; rom_ack = ack;
    acc = 1'b0; drop = 1'b0;
    if (wr && idx == 8'd0 && ioctl_download) begin
      if (exp_q.size() < DEPTH || (ack && exp_q.size() > 0)) acc = 1'b1;
      else drop = 1'b1;
    end
    @(posedge clk_sys);
    if (acc) begin
      e.addr = addr; e.data = dout;
      exp_q.push_back(e);
    end
    if (drop) ovf_m = 1'b1;
    if (wr && idx == 8'd1) tno_m = dout[3:0];
    if (wr && idx == 8'd254 && addr[ADDR_W-1:3] == '0 && addr[2:0] < 3'd3)
      sw_m[int'(addr[2:0])] = dout;
    #1 ioctl_wr = 1'b0;
  endtask

  task automatic idle(input int n, input bit ack);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 8'd0, '0, 8'd0, ack);
  endtask

  task automatic set_dl(input bit v);
    if (v && !ioctl_download) ovf_m = 1'b0;
    ioctl_download = v;
  endtask

  // Counts consecutive cycles with core_reset high, starting at the next negedge.
  task automatic measure_hold(input string nm);
    int n;
    n = 0;
    @(negedge clk_sys);
    while (core_reset === 1'b1 && n < 4 * HOLD + 50) begin
      n++;
      @(negedge clk_sys);
    end
    check(nm, n, HOLD);
    @(posedge clk_sys); #1;
  endtask

  task automatic wait_run(input string nm);
    int n;
    n = 0;
    while (core_reset !== 1'b0 && n < 4 * HOLD + 50) begin
      idle(1, rom_ack);
      n++;
    end
    check(nm, core_reset, 1'b0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int x0;
    for (int i = 0; i < 3; i++) sw_m[i] = '0;

    repeat (3) @(posedge clk_sys);
    #1;
    check("rst_core_reset", core_reset, 1'b1);
    check("rst_rom_req", rom_req, 1'b0);
    check("rst_wait", ioctl_wait, 1'b0);
    check("rst_tno", tno, 4'd0);
    check("rst_dsw", dsw, 24'd0);
    check("rst_overflow", overflow, 1'b0);

    // Post-reset hold window.
    RESET = 1'b0;
    fill_prev = 0;
    mon_en = 1'b1;
    measure_hold("post_reset_hold");

    // ROM stream with ack tied high.
    set_dl(1'b1);
    idle(1, 1'b1);
    for (int i = 0; i < 16; i++) drive_cycle(1'b1, 8'd0, ADDR_W'(i), 8'($urandom), 1'b1);
    set_dl(1'b0);
    x0 = n_xfer;
    idle(1, 1'b1);
    check("stream_all_written", n_xfer, 16);
    check("stream_q_empty", exp_q.size(), 0);
    measure_hold("stream_hold");
    check("stream_x0", x0, 15);

    // Backpressure and overflow.
    set_dl(1'b1);
    idle(1, 1'b0);
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 8'd0, ADDR_W'(32 + i), 8'($urandom), 1'b0);
    idle(1, 1'b0);
    check("wait_after_3", ioctl_wait, 1'b1);
    check("no_ovf_yet", overflow, 1'b0);
    for (int i = 3; i < 5; i++) drive_cycle(1'b1, 8'd0, ADDR_W'(32 + i), 8'($urandom), 1'b0);
    idle(1, 1'b0);
    check("overflow_set", overflow, ovf_m);
    check("overflow_is_1", overflow, 1'b1);
    x0 = n_xfer;
    idle(8, 1'b1);
    check("bp_emitted_4", n_xfer - x0, 4);
    check("bp_wait_clear", ioctl_wait, 1'b0);
    set_dl(1'b0);
    wait_run("bp_run");
    check("overflow_sticky", overflow, 1'b1);

    // DIP and title-number sinks.
    drive_cycle(1'b1, 8'd254, 25'd0, 8'hA5, 1'b0);
    drive_cycle(1'b1, 8'd254, 25'd1, 8'h3C, 1'b0);
    drive_cycle(1'b1, 8'd254, 25'd2, 8'hF0, 1'b0);
    drive_cycle(1'b1, 8'd1,   25'd0, 8'h02, 1'b0);
    idle(2, 1'b0);
    check("dsw_tno2", dsw, 24'h00_3CA5);
    check("tno_2", tno, 4'd2);
    drive_cycle(1'b1, 8'd1, 25'd0, 8'h00, 1'b0);
    idle(2, 1'b0);
    check("dsw_tno0", dsw, 24'hF0_3CA5);
    drive_cycle(1'b1, 8'd254, 25'd5, 8'h77, 1'b0);
    drive_cycle(1'b1, 8'd254, 25'd8, 8'h66, 1'b0);
    idle(2, 1'b0);
    check("dsw_addr5_ignored", dsw, 24'hF0_3CA5);
    for (int i = 0; i < 24; i++) begin
      logic [7:0]        idx;
      logic [ADDR_W-1:0] a;
      case ($urandom_range(0, 3))
        0:       idx = 8'd1;
        1, 2:    idx = 8'd254;
        default: idx = 8'($urandom_range(2, 253));
      endcase
      a = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 7));
      drive_cycle(1'b1, idx, a, 8'($urandom), 1'b0);
      idle(1, 1'b0);
      check("rand_dsw", dsw, exp_dsw());
      check("rand_tno", tno, tno_m);
    end
    check("side_no_fsm_effect", core_reset, 1'b0);

    // Randomized ROM traffic with random ack, wait ignored so drops may occur.
    set_dl(1'b1);
    idle(1, 1'b0);
    for (int i = 0; i < 48; i++)
      drive_cycle($urandom_range(0, 9) < 7, 8'd0, ADDR_W'(100 + i), 8'($urandom),
                  $urandom_range(0, 1) == 1);
    for (int i = 0; i < 12 && exp_q.size() > 0; i++) idle(1, 1'b1);
    check("rand_q_drained", exp_q.size(), 0);
    check("rand_overflow", overflow, ovf_m);
    set_dl(1'b0);
    wait_run("rand_run");

    // Drain after download end, one ack every four cycles.
    set_dl(1'b1);
    idle(2, 1'b0);
    check("ovf_cleared_on_rise", overflow, 1'b0);
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 8'd0, ADDR_W'(200 + i), 8'($urandom), 1'b0);
    set_dl(1'b0);
    for (int k = 0; k < 3; k++) begin
      idle(3, 1'b0);
      check("drain_core_reset", core_reset, 1'b1);
      idle(1, 1'b1);
    end
    rom_ack = 1'b0;
    check("drain_q_empty", exp_q.size(), 0);
    measure_hold("drain_hold");

    // rst_req: single-cycle pulse, then a held request.
    rst_req = 1'b1;
    idle(1, 1'b0);
    rst_req = 1'b0;
    check("rst_req_next_cycle", core_reset, 1'b1);
    measure_hold("rst_req_pulse_hold");
    rst_req = 1'b1;
    idle(5, 1'b0);
    rst_req = 1'b0;
    measure_hold("rst_req_held_hold");

    // Asynchronous RESET while draining.
    set_dl(1'b1);
    idle(1, 1'b0);
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 8'd0, ADDR_W'(300 + i), 8'($urandom), 1'b0);
    set_dl(1'b0);
    idle(2, 1'b0);
    check("pre_reset_req", rom_req, 1'b1);
    mon_en = 1'b0;
    #2 RESET = 1'b1;
    #1;
    check("async_rom_req", rom_req, 1'b0);
    check("async_core_reset", core_reset, 1'b1);
    check("async_dsw", dsw, 24'd0);
    check("async_tno", tno, 4'd0);
    exp_q.delete();
    for (int i = 0; i < 3; i++) sw_m[i] = '0;
    tno_m = '0;
    ovf_m = 1'b0;
    repeat (2) @(posedge clk_sys);
    #1 RESET = 1'b0;
    fill_prev = 0;
    mon_en = 1'b1;
    idle(4, 1'b1);
    check("post_async_fifo_empty", rom_req, 1'b0);
    check("post_async_core_reset", core_reset, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
